// File: rtl/hdmi_line_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_line_fetch_ctrl
// Brief    : Ping-pong line-buffer scheduler feeding the HDMI pixel path.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_line_fetch_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vs,
  input  logic        de,
  output logic        fill_req,
  input  logic        fill_ack,
  output logic [9:0]  fill_line,
  output logic        fill_bank,
  input  logic        fill_done,
  output logic        buffer_rd,
  output logic [10:0] RD_ADDR,
  output logic        underrun,
  output logic        frame_start
);

  localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0] c_x_last   = 10'(H_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BUSY  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_first;
  logic        r_vs_q;
  logic        r_de_q;
  logic [1:0]  r_valid;
  logic [1:0]  w_valid_nxt;
  logic        r_disp_bank;
  logic [9:0]  r_disp_line;
  logic        r_next_bank;
  logic [9:0]  r_next_line;
  logic [9:0]  r_x;

  logic        w_fs;
  logic        w_fs_edge;
  logic        w_de_rise;
  logic        w_de_fall;
  logic        w_disp_act;
  logic        w_fill_ok;
  logic [9:0]  w_x;

  // r_vs_q resets high so a vs already high at reset release is not an edge
  assign w_fs_edge  = vs & ~r_vs_q;
  assign w_fs       = r_first | w_fs_edge;
  assign w_de_rise  = de & ~r_de_q;
  assign w_de_fall  = ~de & r_de_q;
  assign w_disp_act = (r_disp_line < c_v_active);
  assign w_fill_ok  = (r_state == S_BUSY) & fill_done & ~w_fs;
  assign w_x        = w_de_rise ? 10'd0 : r_x;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_fs && (r_next_line < c_v_active) && !r_valid[r_next_bank])
          w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_fs)
          w_state_nxt = S_DRAIN;
        else if (fill_ack)
          w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        // A completion coinciding with a frame start is simply discarded
        if (fill_done)
          w_state_nxt = S_IDLE;
        else if (w_fs)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (fill_done)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Display-side clear is applied after the fill set so it wins on a clash
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_fill_ok)
      w_valid_nxt[r_next_bank] = 1'b1;
    if (w_de_fall && w_disp_act)
      w_valid_nxt[r_disp_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b1;
      r_vs_q      <= 1'b1;
      r_de_q      <= 1'b0;
      r_valid     <= 2'b00;
      r_disp_bank <= 1'b0;
      r_disp_line <= 10'd0;
      r_next_bank <= 1'b0;
      r_next_line <= 10'd0;
      r_x         <= 10'd0;
      fill_req    <= 1'b0;
      fill_line   <= 10'd0;
      fill_bank   <= 1'b0;
      buffer_rd   <= 1'b0;
      RD_ADDR     <= 11'd0;
      underrun    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_first     <= 1'b0;
      r_vs_q      <= vs;
      r_de_q      <= de;
      r_state     <= w_state_nxt;
      frame_start <= w_fs_edge;
      fill_req    <= (w_state_nxt == S_REQ);
      if ((r_state == S_IDLE) && (w_state_nxt == S_REQ)) begin
        fill_line <= r_next_line;
        fill_bank <= r_next_bank;
      end

      buffer_rd <= de & w_disp_act;
      if (de && w_disp_act)
        RD_ADDR <= {r_disp_bank, w_x};
      if (de)
        r_x <= (w_x < c_x_last) ? (w_x + 10'd1) : w_x;

      if (w_fs) begin
        r_valid     <= 2'b00;
        r_disp_bank <= 1'b0;
        r_disp_line <= 10'd0;
        r_next_bank <= 1'b0;
        r_next_line <= 10'd0;
        underrun    <= 1'b0;
      end else begin
        r_valid <= w_valid_nxt;
        if (w_fill_ok) begin
          r_next_line <= r_next_line + 10'd1;
          r_next_bank <= ~r_next_bank;
        end
        if (w_de_rise && w_disp_act && !r_valid[r_disp_bank])
          underrun <= 1'b1;
        if (w_de_fall && w_disp_act) begin
          r_disp_bank <= ~r_disp_bank;
          r_disp_line <= r_disp_line + 10'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_line_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_line_fetch_ctrl
// Brief    : Directed self-checking bench for hdmi_line_fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_line_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs;
  logic        de;
  logic        fill_req;
  logic        fill_ack;
  logic [9:0]  fill_line;
  logic        fill_bank;
  logic        fill_done;
  logic        buffer_rd;
  logic [10:0] RD_ADDR;
  logic        underrun;
  logic        frame_start;

  int errors = 0;
  int checks = 0;
  int fs_cnt = 0;
  int done_cnt = 0;
  bit mem_auto = 1'b0;
  bit hold_done = 1'b0;
  int req_log[$];

  hdmi_line_fetch_ctrl #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vs         (vs),
    .de         (de),
    .fill_req   (fill_req),
    .fill_ack   (fill_ack),
    .fill_line  (fill_line),
    .fill_bank  (fill_bank),
    .fill_done  (fill_done),
    .buffer_rd  (buffer_rd),
    .RD_ADDR    (RD_ADDR),
    .underrun   (underrun),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Request entries are encoded as bank*1024 + line
  task automatic check_req(input string tag, input int exp);
    if (req_log.size() == 0)
      check(tag, 32'hFFFF_FFFF, exp);
    else
      check(tag, req_log.pop_front(), exp);
  endtask

  // One clock: sample at the falling edge, then run the memory-side responder
  task automatic step();
    @(negedge clk);
    if (frame_start === 1'b1) fs_cnt++;
    fill_done = 1'b0;
    if (mem_auto) begin
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0 && !hold_done) fill_done = 1'b1;
      end
      fill_ack = fill_req;
      if (fill_req === 1'b1) begin
        req_log.push_back(int'({fill_bank, fill_line}));
        done_cnt = 5;
      end
    end
  endtask

  task automatic de_pulse(input int len, input int bank, input bit rd_exp, input bit clash,
                          inout int bad_rd, inout int bad_addr);
    de = 1'b1;
    for (int i = 0; i < len; i++) begin
      step();
      if (buffer_rd !== rd_exp) bad_rd++;
      if (rd_exp && (RD_ADDR !== 11'(bank * 1024 + i))) bad_addr++;
      if (i == len - 1) begin
        de = 1'b0;
        if (clash) fill_done = 1'b1;
      end
    end
    step();
    if (buffer_rd !== 1'b0) bad_rd++;
  endtask

  initial begin
    int bad_rd;
    int bad_addr;
    reset_n   = 1'b0;
    vs        = 1'b1;
    de        = 1'b0;
    fill_ack  = 1'b0;
    fill_done = 1'b0;
    mem_auto  = 1'b1;
    repeat (3) step();
    check("rst_fill_req", fill_req, 0);
    check("rst_fill_tag", {fill_bank, fill_line}, 0);
    check("rst_rd", {buffer_rd, RD_ADDR}, 0);
    check("rst_flags", {underrun, frame_start}, 0);

    // Prefetch of lines 0 and 1 after reset
    reset_n = 1'b1;
    repeat (40) step();
    check("pre_req_cnt", req_log.size(), 2);
    check_req("pre_line0", 0);
    check_req("pre_line1", 1024 + 1);
    check("pre_idle", fill_req, 0);
    check("pre_no_fs", fs_cnt, 0);

    // Full-width lines: bank 0 then bank 1
    bad_rd = 0; bad_addr = 0;
    de_pulse(640, 0, 1'b1, 1'b0, bad_rd, bad_addr);
    check("l0_rd", bad_rd, 0);
    check("l0_addr", bad_addr, 0);
    repeat (20) step();
    check_req("l2_req", 2);
    bad_rd = 0; bad_addr = 0;
    de_pulse(640, 1, 1'b1, 1'b0, bad_rd, bad_addr);
    check("l1_rd", bad_rd, 0);
    check("l1_addr", bad_addr, 0);

    // Withhold line 3 so bank 1 underruns, then clash done with de fall
    hold_done = 1'b1;
    repeat (20) step();
    check_req("l3_req", 1024 + 3);
    bad_rd = 0; bad_addr = 0;
    de_pulse(4, 0, 1'b1, 1'b0, bad_rd, bad_addr);
    check("l2_rd", bad_rd + bad_addr, 0);
    check("l2_no_ur", underrun, 0);
    repeat (10) step();
    bad_rd = 0; bad_addr = 0;
    de_pulse(4, 1, 1'b1, 1'b1, bad_rd, bad_addr);
    hold_done = 1'b0;
    check("ur_set", underrun, 1);
    check("ur_rd_bank1", bad_rd + bad_addr, 0);
    repeat (30) step();
    check_req("clash_next_line", 4);
    check_req("clash_valid_clr", 1024 + 5);

    // Frame restart while line 7 is in BUSY
    bad_rd = 0; bad_addr = 0;
    de_pulse(4, 0, 1'b1, 1'b0, bad_rd, bad_addr);
    repeat (20) step();
    check_req("l6_req", 6);
    de_pulse(4, 1, 1'b1, 1'b0, bad_rd, bad_addr);
    check("l45_rd", bad_rd + bad_addr, 0);
    hold_done = 1'b1;
    repeat (10) step();
    check_req("l7_req", 1024 + 7);
    check("busy_no_req", fill_req, 0);
    check("ur_sticky", underrun, 1);
    vs = 1'b0;
    repeat (3) step();
    vs = 1'b1;
    step();
    check("fs_pulse", frame_start, 1);
    check("ur_clr", underrun, 0);
    step();
    check("fs_single", frame_start, 0);
    repeat (10) step();
    check("drain_no_req", req_log.size(), 0);
    fill_done = 1'b1;
    step();
    hold_done = 1'b0;
    repeat (30) step();
    check_req("restart_l0", 0);
    check_req("restart_l1", 1024 + 1);
    check("fs_cnt", fs_cnt, 1);

    // Whole frame of short lines, then lines beyond the active region
    bad_rd = 0; bad_addr = 0;
    for (int k = 0; k < 480; k++) begin
      de_pulse(4, k % 2, 1'b1, 1'b0, bad_rd, bad_addr);
      repeat (12) step();
    end
    check("frame_rd", bad_rd, 0);
    check("frame_addr", bad_addr, 0);
    check("frame_req_cnt", req_log.size(), 478);
    check("frame_last_req", (req_log.size() > 0) ? req_log[$] : -1, 1024 + 479);
    check("frame_no_ur", underrun, 0);
    req_log.delete();
    bad_rd = 0; bad_addr = 0;
    for (int k = 0; k < 3; k++)
      de_pulse(4, 0, 1'b0, 1'b0, bad_rd, bad_addr);
    repeat (20) step();
    check("eof_no_rd", bad_rd, 0);
    check("eof_no_req", req_log.size(), 0);
    check("eof_ur", underrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdmi_line_fetch_ctrl.md
# hdmi_line_fetch_ctrl

Ping-pong line-buffer scheduler between the frame memory and the HDMI RGB timing generator. It watches the generator's `vs`/`de` outputs and issues line-fill requests to the memory side, one line ahead of display. It then produces the `buffer_rd`/`RD_ADDR` read strobe and address that the timing generator's pixel path consumes. It also flags any line that is displayed before its fill has completed.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.

Ports:
- `clk` in 1: pixel clock, the same clock as the timing generator.
- `reset_n` in 1: asynchronous, active-low reset.
- `vs` in 1: vertical sync from the timing generator. It is low during sync and high otherwise.
- `de` in 1: data enable from the timing generator.
- `fill_req` out 1: line-fill request to the memory side.
- `fill_ack` in 1: memory side has accepted the request.
- `fill_line` out 10: line number to fetch. Valid while `fill_req` is high.
- `fill_bank` out 1: line-buffer bank that the memory side writes into.
- `fill_done` in 1: single-cycle pulse meaning the line is fully written.
- `buffer_rd` out 1: line-buffer read enable.
- `RD_ADDR` out 11: line-buffer read address, formed as {bank, x[9:0]}.
- `underrun` out 1: sticky flag, cleared at each frame start.
- `frame_start` out 1: single-cycle pulse on the rising edge of `vs`.

## Operation
Internal state:
- `valid[1:0]`: per-bank fill-complete flag.
- `disp_bank`, `disp_line`: bank and line currently being displayed.
- `next_line`, `next_bank`: next line to fill and the bank it goes into.
- Fill FSM with states IDLE, REQ, BUSY and DRAIN.
- `x`: pixel counter within the line.

Frame start:
- Triggered by a rising edge of `vs` (previous `vs` = 0, current `vs` = 1). It also occurs once, implicitly, on the first cycle after reset.
- Sets `valid`=00, `disp_bank`=0, `disp_line`=0, `next_line`=0, `next_bank`=0, `underrun`=0.
- Pulses `frame_start` only on a real `vs` edge, not on the implicit post-reset start.

Fill FSM:
- IDLE → REQ when `next_line` < `V_ACTIVE` and `valid[next_bank]`=0.
- REQ: hold `fill_req`=1 with stable `fill_line`/`fill_bank` until `fill_ack`=1, then go to BUSY.
- BUSY: wait for `fill_done`. On `fill_done`, set `valid[next_bank]`, increment `next_line`, toggle `next_bank`, and return to IDLE.
- A frame start during REQ or BUSY moves the FSM to DRAIN (see below). The memory transaction cannot be aborted.
  - A frame start during REQ withdraws `fill_req` on the next cycle, unless `fill_ack` arrives in the same cycle. In that case the FSM still goes to DRAIN.
- DRAIN: wait for `fill_done`, discard it (no change to `valid` or counters), then go to IDLE.
- A frame start in IDLE only applies the frame-start resets.

Display side:
- On a rising edge of `de`:
  - clear `x` to 0;
  - if `disp_line` < `V_ACTIVE` and `valid[disp_bank]`=0, set `underrun`.
- While `de`=1: read from {`disp_bank`, `x`}. `x` increments each cycle and saturates at `H_ACTIVE`-1.
- On a falling edge of `de`, if `disp_line` < `V_ACTIVE`: clear `valid[disp_bank]`, toggle `disp_bank`, increment `disp_line`.
- Once `disp_line` ≥ `V_ACTIVE`: `buffer_rd` is suppressed, and neither `underrun` nor `valid` is touched.

Simultaneous events:
- `fill_done` and `de` falling edge in the same cycle, same bank (only possible after an underrun): the clear wins, so `valid` ends at 0. The fill still advances `next_line`/`next_bank`.
- Frame start in the same cycle as a `de` edge: frame start wins.

## Timing
- Reset values: `fill_req`=0, `fill_line`=0, `fill_bank`=0, `buffer_rd`=0, `RD_ADDR`=0, `underrun`=0, `frame_start`=0. FSM in IDLE, `valid`=00.
- All outputs are registered.
- `buffer_rd` and `RD_ADDR` lag `de` by exactly 1 cycle. Pixel data returns one cycle later, which aligns with the timing generator's two-stage `de` pipeline.
- `fill_req` rises 1 cycle after the IDLE→REQ condition becomes true. `fill_req` falls in the cycle after `fill_ack` is sampled high.
- `frame_start` is high for the single cycle after the rising edge of `vs` is sampled.
- If `reset_n` is asserted mid-transaction, everything returns immediately to reset values. The memory side must also be reset.

## Test plan
- **Prefetch.** Release reset with `fill_ack` tied to `fill_req` and `fill_done` 5 cycles after the ack.
  - Expected: line 0 is requested into bank 0, then line 1 into bank 1.
  - FSM then sits in IDLE (both banks valid) until the first `de` falling edge, after which line 2 is requested into bank 0.
- **Read addressing.** Hold a 640-cycle `de` pulse with bank 0 valid.
  - Expected: `buffer_rd` is high for 640 cycles starting 1 cycle after `de`.
  - `RD_ADDR` runs 0x000 to 0x27F. On the next line it runs 0x400 to 0x67F.
- **Underrun.** Withhold `fill_done` for line 1, then start the second `de` pulse.
  - Expected: `underrun`=1 and reads still target bank 1.
  - `underrun` returns to 0 on the next rising edge of `vs`.
- **Frame restart mid-fill.** Raise `vs` while the FSM is in BUSY on line 7.
  - Expected: `frame_start` pulses and `valid`=00 (clearing is part of frame start).
  - The later `fill_done` is ignored, and the next `fill_req` carries line 0, bank 0.
- **End of frame.** After 480 lines, drive extra `de` pulses.
  - Expected: no `buffer_rd`, no new `fill_req`, and `underrun` unchanged.
- **Same-cycle clash.** Assert `fill_done` on the cycle that `de` falls for a bank that underran.
  - Expected: that bank's `valid` ends at 0 and `next_line` is incremented.
